mac_cam_lut: RTL and testbench

- Learning MAC address table for the 1G switch port output-port lookup.
- Consumes the register-side read/write requests and drives the hit/miss pulses that feed the op-LUT register block.
- Serves per-packet lookup requests from the header parser: destination lookup plus source-MAC learning.
- Small fully-associative table; all accesses are serialised by one FSM.

---
 rtl/mac_lut_pkg.sv | 26 ++
 rtl/mac_lut_match.sv | 40 ++++
 rtl/mac_cam_lut.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_mac_cam_lut.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_lut_pkg.sv
// Shared definitions for the learning MAC lookup table: FSM state encoding,
// MAC field width, multicast bit position and aging period.
package mac_lut_pkg;

    localparam int MAC_W           = 48;
    localparam int MULTICAST_BIT   = 40;
    localparam int AGE_PERIOD_LOG2 = 24;
    localparam int AGE_CNT_W       = 32;

    typedef logic [MAC_W-1:0] mac_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_RESULT,
        ST_LEARN,
        ST_REG_RD,
        ST_REG_WR
    } state_e;

    // Group/multicast source addresses are never learned.
    function automatic logic is_multicast(input mac_t mac);
        return mac[MULTICAST_BIT];
    endfunction

endpackage

// File: rtl/mac_lut_match.sv
// Two-key parallel comparator over all table entries. For each key it reports
// whether any valid entry matches and the lowest matching index.
module mac_lut_match
    import mac_lut_pkg::*;
#(
    parameter int DEPTH_BITS = 4
) (
    input  logic [MAC_W-1:0]         key_a_i,
    input  logic [MAC_W-1:0]         key_b_i,
    input  logic [MAC_W-1:0]         entry_mac_i [2**DEPTH_BITS],
    input  logic [2**DEPTH_BITS-1:0] entry_valid_i,
    output logic                     a_hit_o,
    output logic [DEPTH_BITS-1:0]    a_idx_o,
    output logic                     b_hit_o,
    output logic [DEPTH_BITS-1:0]    b_idx_o
);

    localparam int DEPTH = 2 ** DEPTH_BITS;

    // Scan from the top down so the lowest matching index is the last one kept.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that leaves
        // one unassigned would infer a latch.
        a_hit_o = 1'b0;
        a_idx_o = '0;
        b_hit_o = 1'b0;
        b_idx_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entry_valid_i[i] && (entry_mac_i[i] == key_a_i)) begin
                a_hit_o = 1'b1;
                a_idx_o = DEPTH_BITS'(i);
            end
            if (entry_valid_i[i] && (entry_mac_i[i] == key_b_i)) begin
                b_hit_o = 1'b1;
                b_idx_o = DEPTH_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/mac_cam_lut.sv
// Learning MAC address table for the switch output-port lookup. One FSM
// serialises per-packet lookups (destination search plus source learning)
// and register-side reads and writes of individual entries.
// Optional entry aging is enabled by defining MAC_LUT_AGING_EN.
module mac_cam_lut
    import mac_lut_pkg::*;
#(
    parameter int NUM_OUTPUT_QUEUES = 5,
    parameter int LUT_DEPTH_BITS    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         lookup_req,
    output logic                         lookup_rdy,
    input  logic [MAC_W-1:0]             lookup_dst_mac,
    input  logic [MAC_W-1:0]             lookup_src_mac,
    input  logic [NUM_OUTPUT_QUEUES-1:0] lookup_src_port,
    output logic                         lookup_done,
    output logic [NUM_OUTPUT_QUEUES-1:0] lookup_dst_oq,
    output logic                         lut_hit,
    output logic                         lut_miss,
    input  logic [LUT_DEPTH_BITS-1:0]    rd_addr,
    input  logic                         rd_req,
    output logic [NUM_OUTPUT_QUEUES-1:0] rd_oq,
    output logic                         rd_wr_protect,
    output logic [MAC_W-1:0]             rd_mac,
    output logic                         rd_ack,
    input  logic [LUT_DEPTH_BITS-1:0]    wr_addr,
    input  logic                         wr_req,
    input  logic [NUM_OUTPUT_QUEUES-1:0] wr_oq,
    input  logic                         wr_protect,
    input  logic [MAC_W-1:0]             wr_mac,
    output logic                         wr_ack
);

    localparam int LUT_DEPTH = 2 ** LUT_DEPTH_BITS;

    typedef logic [NUM_OUTPUT_QUEUES-1:0] oq_t;
    typedef logic [LUT_DEPTH_BITS-1:0]    idx_t;

    // Table storage
    mac_t                 mac_q [LUT_DEPTH];
    oq_t                  oq_q  [LUT_DEPTH];
    logic [LUT_DEPTH-1:0] prot_q;
    logic [LUT_DEPTH-1:0] valid_q;

    // Control state
    state_e state_q, state_d;
    mac_t   dst_mac_q, src_mac_q;
    oq_t    src_port_q;
    logic   dst_hit, src_hit, dst_hit_q, src_hit_q;
    idx_t   dst_idx, src_idx, dst_idx_q, src_idx_q;
    idx_t   replace_ptr_q, replace_ptr_d;
    idx_t   learn_idx_q, learn_idx_d;

    // Output registers
    logic   done_q, done_d, hit_q, hit_d, miss_q, miss_d;
    oq_t    dst_oq_q, dst_oq_d;
    logic   rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
    mac_t   rd_mac_q;
    oq_t    rd_oq_q;
    logic   rd_prot_q;

    // Single table write port, shared by learning and register writes
    logic   accept_lookup, rd_load;
    logic   tbl_we;
    idx_t   tbl_idx;
    mac_t   tbl_mac;
    oq_t    tbl_oq;
    logic   tbl_prot, tbl_valid;

`ifdef MAC_LUT_AGING_EN
    logic [LUT_DEPTH-1:0] used_q;
    logic [AGE_CNT_W-1:0] age_cnt_q;
    logic                 age_pending_q;
    logic                 age_pulse;
    logic                 age_now;

    assign age_pulse = (age_cnt_q[AGE_PERIOD_LOG2-1:0] == '1);
    assign age_now   = age_pending_q && (state_q == ST_IDLE);
`endif

    mac_lut_match #(
        .DEPTH_BITS (LUT_DEPTH_BITS)
    ) u_match (
        .key_a_i       (dst_mac_q),
        .key_b_i       (src_mac_q),
        .entry_mac_i   (mac_q),
        .entry_valid_i (valid_q),
        .a_hit_o       (dst_hit),
        .a_idx_o       (dst_idx),
        .b_hit_o       (src_hit),
        .b_idx_o       (src_idx)
    );

    // Next-state, result strobes, learn decision and table write selection
    always_comb begin
        state_d       = state_q;
        replace_ptr_d = replace_ptr_q;
        learn_idx_d   = learn_idx_q;
        done_d        = 1'b0;
        hit_d         = 1'b0;
        miss_d        = 1'b0;
        dst_oq_d      = '0;
        rd_ack_d      = 1'b0;
        wr_ack_d      = 1'b0;
        accept_lookup = 1'b0;
        rd_load       = 1'b0;
        tbl_we        = 1'b0;
        tbl_idx       = learn_idx_q;
        tbl_mac       = src_mac_q;
        tbl_oq        = src_port_q;
        tbl_prot      = 1'b0;
        tbl_valid     = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (lookup_req) begin
                    accept_lookup = 1'b1;
                    state_d       = ST_COMPARE;
                end else if (wr_req) begin
                    tbl_we    = 1'b1;
                    tbl_idx   = wr_addr;
                    tbl_mac   = wr_mac;
                    tbl_oq    = wr_oq;
                    tbl_prot  = wr_protect;
                    tbl_valid = |wr_mac;
                    state_d   = ST_REG_WR;
                end else if (rd_req) begin
                    rd_load = 1'b1;
                    state_d = ST_REG_RD;
                end
            end

            ST_COMPARE: state_d = ST_RESULT;

            ST_RESULT: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (dst_hit_q) begin
                    hit_d    = 1'b1;
                    dst_oq_d = oq_q[dst_idx_q] & ~src_port_q;
                end else begin
                    miss_d   = 1'b1;
                    dst_oq_d = ~src_port_q;
                end
                if (!is_multicast(src_mac_q)) begin
                    if (src_hit_q) begin
                        if (!prot_q[src_idx_q] && (oq_q[src_idx_q] != src_port_q)) begin
                            learn_idx_d = src_idx_q;
                            state_d     = ST_LEARN;
                        end
                    end else begin
                        replace_ptr_d = replace_ptr_q + 1'b1;
                        if (!prot_q[replace_ptr_q]) begin
                            learn_idx_d = replace_ptr_q;
                            state_d     = ST_LEARN;
                        end
                    end
                end
            end

            ST_LEARN: begin
                tbl_we  = 1'b1;
                state_d = ST_IDLE;
            end

            ST_REG_RD: begin
                if (rd_req) rd_ack_d = 1'b1;
                else        state_d  = ST_IDLE;
            end

            ST_REG_WR: begin
                if (wr_req) wr_ack_d = 1'b1;
                else        state_d  = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, lookup context, match results and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            dst_mac_q     <= '0;
            src_mac_q     <= '0;
            src_port_q    <= '0;
            dst_hit_q     <= 1'b0;
            src_hit_q     <= 1'b0;
            dst_idx_q     <= '0;
            src_idx_q     <= '0;
            replace_ptr_q <= '0;
            learn_idx_q   <= '0;
            done_q        <= 1'b0;
            hit_q         <= 1'b0;
            miss_q        <= 1'b0;
            dst_oq_q      <= '0;
            rd_ack_q      <= 1'b0;
            wr_ack_q      <= 1'b0;
            rd_mac_q      <= '0;
            rd_oq_q       <= '0;
            rd_prot_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values, independent of statement order.
            state_q       <= state_d;
            replace_ptr_q <= replace_ptr_d;
            learn_idx_q   <= learn_idx_d;
            done_q        <= done_d;
            hit_q         <= hit_d;
            miss_q        <= miss_d;
            dst_oq_q      <= dst_oq_d;
            rd_ack_q      <= rd_ack_d;
            wr_ack_q      <= wr_ack_d;
            if (accept_lookup) begin
                dst_mac_q  <= lookup_dst_mac;
                src_mac_q  <= lookup_src_mac;
                src_port_q <= lookup_src_port;
            end
            if (state_q == ST_COMPARE) begin
                dst_hit_q <= dst_hit;
                dst_idx_q <= dst_idx;
                src_hit_q <= src_hit;
                src_idx_q <= src_idx;
            end
            if (rd_load) begin
                rd_mac_q  <= mac_q[rd_addr];
                rd_oq_q   <= oq_q[rd_addr];
                rd_prot_q <= prot_q[rd_addr];
            end
        end
    end

    // Table contents: aging sweep first, then the single write port overrides
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the table is held in flops and is reset explicitly, because
            // stale valid bits after reset would produce false hits.
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mac_q[i] <= '0;
                oq_q[i]  <= '0;
            end
            prot_q  <= '0;
            valid_q <= '0;
`ifdef MAC_LUT_AGING_EN
            used_q  <= '0;
`endif
        end else begin
`ifdef MAC_LUT_AGING_EN
            if (age_now) begin
                for (int i = 0; i < LUT_DEPTH; i++) begin
                    if (valid_q[i] && !prot_q[i] && !used_q[i]) valid_q[i] <= 1'b0;
                end
                used_q <= '0;
            end
            if (state_q == ST_RESULT) begin
                if (dst_hit_q) used_q[dst_idx_q] <= 1'b1;
                if (src_hit_q) used_q[src_idx_q] <= 1'b1;
            end
`endif
            if (tbl_we) begin
                mac_q[tbl_idx]   <= tbl_mac;
                oq_q[tbl_idx]    <= tbl_oq;
                prot_q[tbl_idx]  <= tbl_prot;
                valid_q[tbl_idx] <= tbl_valid;
`ifdef MAC_LUT_AGING_EN
                used_q[tbl_idx]  <= 1'b1;
`endif
            end
        end
    end

`ifdef MAC_LUT_AGING_EN
    // Free-running age timer; a pulse is held pending until the FSM is idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age_cnt_q     <= '0;
            age_pending_q <= 1'b0;
        end else begin
            age_cnt_q     <= age_cnt_q + 1'b1;
            age_pending_q <= age_pulse || (age_pending_q && (state_q != ST_IDLE));
        end
    end
`endif

    assign lookup_rdy    = (state_q == ST_IDLE);
    assign lookup_done   = done_q;
    assign lut_hit       = hit_q;
    assign lut_miss      = miss_q;
    assign lookup_dst_oq = dst_oq_q;
    assign rd_ack        = rd_ack_q;
    assign wr_ack        = wr_ack_q;
    assign rd_mac        = rd_mac_q;
    assign rd_oq         = rd_oq_q;
    assign rd_wr_protect = rd_prot_q;

endmodule

// File: tb/tb_mac_cam_lut.sv
// Self-checking bench for mac_cam_lut: directed scenarios plus randomized
// lookups, register reads and writes checked against a table model.
module tb_mac_cam_lut;

    localparam int NQ    = 5;
    localparam int DB    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          lookup_req;
    logic          lookup_rdy;
    logic [47:0]   lookup_dst_mac, lookup_src_mac;
    logic [NQ-1:0] lookup_src_port;
    logic          lookup_done;
    logic [NQ-1:0] lookup_dst_oq;
    logic          lut_hit, lut_miss;
    logic [DB-1:0] rd_addr;
    logic          rd_req;
    logic [NQ-1:0] rd_oq;
    logic          rd_wr_protect;
    logic [47:0]   rd_mac;
    logic          rd_ack;
    logic [DB-1:0] wr_addr;
    logic          wr_req;
    logic [NQ-1:0] wr_oq;
    logic          wr_protect;
    logic [47:0]   wr_mac;
    logic          wr_ack;

    mac_cam_lut #(
        .NUM_OUTPUT_QUEUES (NQ),
        .LUT_DEPTH_BITS    (DB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .lookup_req      (lookup_req),
        .lookup_rdy      (lookup_rdy),
        .lookup_dst_mac  (lookup_dst_mac),
        .lookup_src_mac  (lookup_src_mac),
        .lookup_src_port (lookup_src_port),
        .lookup_done     (lookup_done),
        .lookup_dst_oq   (lookup_dst_oq),
        .lut_hit         (lut_hit),
        .lut_miss        (lut_miss),
        .rd_addr         (rd_addr),
        .rd_req          (rd_req),
        .rd_oq           (rd_oq),
        .rd_wr_protect   (rd_wr_protect),
        .rd_mac          (rd_mac),
        .rd_ack          (rd_ack),
        .wr_addr         (wr_addr),
        .wr_req          (wr_req),
        .wr_oq           (wr_oq),
        .wr_protect      (wr_protect),
        .wr_mac          (wr_mac),
        .wr_ack          (wr_ack)
    );

    always #5 clk = ~clk;

    // Reference model of the table
    logic [47:0]   m_mac   [DEPTH];
    logic [NQ-1:0] m_oq    [DEPTH];
    bit            m_prot  [DEPTH];
    bit            m_valid [DEPTH];
    int            m_ptr;

    int n_vec = 0;
    int n_err = 0;

    logic [47:0] src_pool [24];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mac[i]   = '0;
            m_oq[i]    = '0;
            m_prot[i]  = 1'b0;
            m_valid[i] = 1'b0;
        end
        m_ptr = 0;
    endfunction

    function automatic int model_find(input logic [47:0] mac);
        for (int i = 0; i < DEPTH; i++)
            if (m_valid[i] && m_mac[i] == mac) return i;
        return -1;
    endfunction

    function automatic logic [NQ-1:0] onehot_port();
        return NQ'(1) << $urandom_range(0, NQ - 1);
    endfunction

    // Lookup transaction; called and returns at a negedge. With watch_wr set,
    // a pending register write must not be acknowledged before lookup_done.
    task automatic do_lookup(input logic [47:0] dst, input logic [47:0] src,
                             input logic [NQ-1:0] port, input bit watch_wr);
        int            di, si, n;
        bit            exp_hit, exp_learn, wr_seen;
        logic [NQ-1:0] exp_oq;

        di        = model_find(dst);
        si        = model_find(src);
        exp_hit   = (di >= 0);
        exp_oq    = exp_hit ? (m_oq[di] & ~port) : ~port;
        exp_learn = 1'b0;
        if (!src[40]) begin
            if (si >= 0) begin
                if (!m_prot[si] && m_oq[si] != port) begin
                    m_oq[si]  = port;
                    exp_learn = 1'b1;
                end
            end else begin
                if (!m_prot[m_ptr]) begin
                    m_mac[m_ptr]   = src;
                    m_oq[m_ptr]    = port;
                    m_prot[m_ptr]  = 1'b0;
                    m_valid[m_ptr] = 1'b1;
                    exp_learn      = 1'b1;
                end
                m_ptr = (m_ptr + 1) % DEPTH;
            end
        end

        lookup_dst_mac  = dst;
        lookup_src_mac  = src;
        lookup_src_port = port;
        lookup_req      = 1'b1;
        n = 0;
        while (!lookup_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("lk_rdy", 64'(lookup_rdy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        lookup_req = 1'b0;
        wr_seen    = wr_ack;
        n = 1;
        while (!lookup_done && n < 20) begin
            @(negedge clk);
            n++;
            if (wr_ack) wr_seen = 1'b1;
        end
        check("lk_done", 64'(lookup_done), 64'd1);
        check("lk_latency", 64'(n), 64'd3);
        check("lk_hit", 64'(lut_hit), 64'(exp_hit));
        check("lk_miss", 64'(lut_miss), 64'(!exp_hit));
        check("lk_dst_oq", 64'(lookup_dst_oq), 64'(exp_oq));
        check("lk_learn_busy", 64'(lookup_rdy), 64'(!exp_learn));
        if (watch_wr) check("lk_wr_ack_early", 64'(wr_seen), 64'd0);
        @(negedge clk);
        check("lk_done_pulse", 64'(lookup_done), 64'd0);
    endtask

    task automatic do_write(input int idx, input logic [47:0] mac, input logic [NQ-1:0] oq,
                            input bit prot, input int hold);
        int n;
        wr_addr    = DB'(idx);
        wr_mac     = mac;
        wr_oq      = oq;
        wr_protect = prot;
        wr_req     = 1'b1;
        n = 0;
        while (!wr_ack && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("wr_ack_rise", 64'(wr_ack), 64'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("wr_ack_hold", 64'(wr_ack), 64'd1);
            check("wr_rdy_low", 64'(lookup_rdy), 64'd0);
        end
        wr_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wr_ack && n < 10);
        check("wr_ack_fall", 64'(wr_ack), 64'd0);
        m_mac[idx]   = mac;
        m_oq[idx]    = oq;
        m_prot[idx]  = prot;
        m_valid[idx] = (mac != 0);
    endtask

    task automatic do_read(input int idx, input int hold);
        int n;
        rd_addr = DB'(idx);
        rd_req  = 1'b1;
        n = 0;
        while (!rd_ack && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("rd_ack_rise", 64'(rd_ack), 64'd1);
        check("rd_mac", 64'(rd_mac), 64'(m_mac[idx]));
        check("rd_oq", 64'(rd_oq), 64'(m_oq[idx]));
        check("rd_prot", 64'(rd_wr_protect), 64'(m_prot[idx]));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("rd_ack_hold", 64'(rd_ack), 64'd1);
        end
        rd_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rd_ack && n < 10);
        check("rd_ack_fall", 64'(rd_ack), 64'd0);
        check("rd_mac_hold", 64'(rd_mac), 64'(m_mac[idx]));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [47:0] dst, src;
        logic [47:0] mac_a, mac_b;
        int          op;

        reset = 1'b1;
        lookup_req = 1'b0; lookup_dst_mac = '0; lookup_src_mac = '0; lookup_src_port = '0;
        rd_req = 1'b0; rd_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_oq = '0; wr_protect = 1'b0; wr_mac = '0;
        model_clear();
        for (int i = 0; i < 24; i++)
            src_pool[i] = {8'h02, 16'($urandom), 16'($urandom), 8'(i)};
        mac_a = 48'h0011_2233_4455;
        mac_b = 48'hAA00_0000_0001;

        repeat (3) @(negedge clk);
        check("rst_rdy", 64'(lookup_rdy), 64'd1);
        check("rst_done", 64'(lookup_done), 64'd0);
        check("rst_hit", 64'(lut_hit), 64'd0);
        check("rst_miss", 64'(lut_miss), 64'd0);
        check("rst_dst_oq", 64'(lookup_dst_oq), 64'd0);
        check("rst_rd_ack", 64'(rd_ack), 64'd0);
        check("rst_wr_ack", 64'(wr_ack), 64'd0);
        check("rst_rd_mac", 64'(rd_mac), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // First lookup misses, floods and learns the source in entry 0
        do_lookup(mac_a, mac_b, 5'b00001, 1'b0);
        do_read(0, 1);

        // Protected static entry, then a destination hit on it
        do_write(3, mac_a, 5'b00100, 1'b1, 2);
        do_lookup(mac_a, mac_b, 5'b00010, 1'b0);

        // Source hits protected entry 3 from another port: no update
        do_lookup(48'h0200_0000_7777, mac_a, 5'b01000, 1'b0);
        do_read(3, 2);

        // Lookup and register write asserted together: lookup wins
        wr_addr = 4'd7; wr_mac = 48'h0200_0000_0707; wr_oq = 5'b10000; wr_protect = 1'b0;
        wr_req  = 1'b1;
        do_lookup(48'h0200_0000_0707, src_pool[0], 5'b00100, 1'b1);
        do_write(7, 48'h0200_0000_0707, 5'b10000, 1'b0, 1);
        do_lookup(48'h0200_0000_0707, src_pool[1], 5'b00001, 1'b0);

        // Zero-MAC write deletes an entry
        do_write(7, 48'h0, 5'b00011, 1'b0, 0);
        do_lookup(48'h0200_0000_0707, src_pool[1], 5'b00001, 1'b0);

        // Randomized traffic mixed with register accesses
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            if (op < 7) begin
                dst = ($urandom_range(0, 3) == 0) ? {8'h02, 40'($urandom)} :
                                                   src_pool[$urandom_range(0, 23)];
                src = src_pool[$urandom_range(0, 23)];
                if ($urandom_range(0, 7) == 0) src = src | 48'h0100_0000_0000;
                do_lookup(dst, src, onehot_port(), 1'b0);
            end else if (op == 7) begin
                do_write($urandom_range(0, DEPTH - 1),
                         ($urandom_range(0, 4) == 0) ? 48'h0 : src_pool[$urandom_range(0, 23)],
                         NQ'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
            end else begin
                do_read($urandom_range(0, DEPTH - 1), $urandom_range(0, 2));
            end
        end

        // Reset during a register write with wr_ack high
        wr_addr = 4'd5; wr_mac = 48'h0200_0000_0505; wr_oq = 5'b00010; wr_protect = 1'b0;
        wr_req  = 1'b1;
        begin
            int n;
            n = 0;
            while (!wr_ack && n < 60) begin
                @(negedge clk);
                n++;
            end
        end
        check("rst_mid_ack_before", 64'(wr_ack), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_wr_ack", 64'(wr_ack), 64'd0);
        check("rst_mid_rdy", 64'(lookup_rdy), 64'd1);
        wr_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        do_read(0, 0);
        do_read(3, 0);
        do_read(5, 0);
        do_lookup(mac_a, 48'h0200_0000_1000, 5'b00001, 1'b0);

        // Fill the table, then wrap the replacement pointer
        for (int i = 1; i < DEPTH; i++)
            do_lookup(48'h0200_0000_1000, 48'h0200_0000_1000 + 48'(i), onehot_port(), 1'b0);
        do_read(15, 0);
        do_lookup(48'h0200_0000_1005, 48'h0200_0000_2000, 5'b00010, 1'b0);
        do_read(0, 0);

        // Protected victim: no write, pointer still advances to the next entry
        do_write(1, 48'h0200_0000_3001, 5'b01000, 1'b1, 0);
        do_lookup(48'h0200_0000_3001, 48'h0200_0000_2001, 5'b00001, 1'b0);
        do_read(1, 0);
        do_lookup(48'h0200_0000_2001, 48'h0200_0000_2002, 5'b00100, 1'b0);
        do_read(2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
